// File: rtl/wr_full_flag_gen_pkg.sv
// Shared definitions for the write-domain full-flag generator: default geometry and Gray helpers.
// The helpers work on a wide word so any pointer width can use them via explicit casts.
package wr_full_flag_gen_pkg;

    localparam int unsigned A_LENGTH_DEF  = 4;
    localparam int unsigned AF_MARGIN_DEF = 2;
    localparam int unsigned FN_W          = 32;

    typedef logic [FN_W-1:0] fn_word_t;

    function automatic fn_word_t bin2gray(input fn_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down, done in log2 steps.
    function automatic fn_word_t gray2bin(input fn_word_t g);
        fn_word_t b;
        b = g;
        for (int unsigned s = 1; s < FN_W; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/wr_full_flag_gen_sync_2ff_bus.sv
// Two-flop bus synchroniser with asynchronous active-high reset.
// Only safe for buses where at most one bit changes per source update (Gray pointers).
module sync_2ff_bus #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/wr_full_flag_gen.sv
// Write-domain full-flag generator for the dual-clock FIFO; full is computed from the next pointer.
// Optional almost-full output is enabled by defining FULL_ALMOST_EN.
module wr_full_flag_gen
    import wr_full_flag_gen_pkg::*;
#(
    parameter int unsigned A_LENGTH  = A_LENGTH_DEF,
    parameter int unsigned AF_MARGIN = AF_MARGIN_DEF
) (
    input  logic              wr_clk,
    input  logic              reset,
    input  logic [A_LENGTH:0] wr_ptr,
    input  logic              enable_wr_out,
    input  logic              enable_wr,
    input  logic [A_LENGTH:0] rd_ptr_gray,
    output logic              f_full,
    output logic [A_LENGTH:0] wr_ptr_gray,
    output logic [A_LENGTH:0] wr_level,
    output logic              wr_overflow
`ifdef FULL_ALMOST_EN
    ,
    output logic              f_almost_full
`endif
);

    localparam int unsigned PTR_W = A_LENGTH + 1;
    localparam int unsigned DEPTH = 1 << A_LENGTH;

    logic [PTR_W-1:0] w_rd_gray_sync;
    logic [PTR_W-1:0] w_rd_bin;
    logic [PTR_W-1:0] w_wr_nxt;
    logic [PTR_W-1:0] w_full_ptr;
    logic [PTR_W-1:0] w_level_nxt;
    logic [PTR_W-1:0] w_wr_gray_nxt;
    logic             w_full_nxt;

    logic             r_full;
    logic [PTR_W-1:0] r_wr_gray;
    logic [PTR_W-1:0] r_level;
    logic             r_overflow;

    // Read pointer crosses into wr_clk as Gray, decoded after the second flop.
    sync_2ff_bus #(
        .WIDTH (PTR_W)
    ) u_rd_sync (
        .i_clk (wr_clk),
        .i_rst (reset),
        .i_d   (rd_ptr_gray),
        .o_q   (w_rd_gray_sync)
    );

    assign w_rd_bin = PTR_W'(gray2bin(FN_W'(w_rd_gray_sync)));

    // Compare against the pointer after this edge's write so full has no lag cycle.
    assign w_wr_nxt      = wr_ptr + PTR_W'(enable_wr_out);
    assign w_full_ptr    = {~w_rd_bin[A_LENGTH], w_rd_bin[A_LENGTH-1:0]};
    assign w_full_nxt    = (w_wr_nxt == w_full_ptr);
    assign w_level_nxt   = w_wr_nxt - w_rd_bin;
    assign w_wr_gray_nxt = PTR_W'(bin2gray(FN_W'(w_wr_nxt)));

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            r_full     <= 1'b0;
            r_wr_gray  <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_full     <= w_full_nxt;
            r_wr_gray  <= w_wr_gray_nxt;
            r_level    <= w_level_nxt;
            r_overflow <= r_overflow | (enable_wr & r_full);
        end
    end

    assign f_full      = r_full;
    assign wr_ptr_gray = r_wr_gray;
    assign wr_level    = r_level;
    assign wr_overflow = r_overflow;

`ifdef FULL_ALMOST_EN
    localparam int unsigned AF_THRESH = (AF_MARGIN > DEPTH) ? 0 : DEPTH - AF_MARGIN;

    logic r_almost_full;

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_level_nxt >= PTR_W'(AF_THRESH));
        end
    end

    assign f_almost_full = r_almost_full;
`else
    // The margin only matters for the almost-full output; a margin beyond DEPTH is simply inert.
    if (AF_MARGIN > DEPTH) begin : g_af_margin_inert
    end
`endif

endmodule

// File: tb/tb_wr_full_flag_gen.sv
// Self-checking bench for wr_full_flag_gen (A_LENGTH=4); define FULL_ALMOST_EN to cover almost-full.
`timescale 1ns/1ps
module tb_wr_full_flag_gen;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned AF_MARGIN = 2;

    logic       wr_clk = 1'b0;
    logic       reset;
    logic [4:0] wr_ptr;
    logic       enable_wr_out;
    logic       enable_wr;
    logic [4:0] rd_ptr_gray;
    logic       f_full;
    logic [4:0] wr_ptr_gray;
    logic [4:0] wr_level;
    logic       wr_overflow;
`ifdef FULL_ALMOST_EN
    logic       f_almost_full;
`endif

    typedef struct {
        logic       full;
        logic [4:0] gray;
        logic [4:0] level;
        logic       ovf;
        logic       af;
    } exp_t;

    exp_t  sb_q[$];
    int    checks   = 0;
    int    failures = 0;
    string cur_test = "none";

    // Bench-side view of the write counter and of what the DUT should have seen.
    logic [4:0] m_wr;
    logic [4:0] rd_d1;
    logic [4:0] rd_d2;
    logic       m_full;
    logic       m_ovf;

    wr_full_flag_gen #(
        .A_LENGTH  (4),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .wr_clk        (wr_clk),
        .reset         (reset),
        .wr_ptr        (wr_ptr),
        .enable_wr_out (enable_wr_out),
        .enable_wr     (enable_wr),
        .rd_ptr_gray   (rd_ptr_gray),
        .f_full        (f_full),
        .wr_ptr_gray   (wr_ptr_gray),
        .wr_level      (wr_level),
        .wr_overflow   (wr_overflow)
`ifdef FULL_ALMOST_EN
        ,
        .f_almost_full (f_almost_full)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        logic [4:0] g;
        g[4] = b[4];
        for (int i = 0; i < 4; i++) g[i] = b[i] ^ b[i+1];
        return g;
    endfunction

    // One write-domain cycle: drive inputs, push the expected result, pop and compare after the edge.
    task automatic step(input logic acc, input logic req, input logic [4:0] rd);
        exp_t       e;
        exp_t       o;
        logic [4:0] nxt;
        logic [4:0] rdv;
        wr_ptr        = m_wr;
        enable_wr_out = acc;
        enable_wr     = req;
        rd_ptr_gray   = to_gray(rd);
        nxt     = m_wr + 5'(acc);
        rdv     = rd_d2;
        e.full  = (nxt == {~rdv[4], rdv[3:0]});
        e.level = nxt - rdv;
        e.gray  = to_gray(nxt);
        e.ovf   = m_ovf | (req & m_full);
        e.af    = (e.level >= 5'(DEPTH - AF_MARGIN));
        sb_q.push_back(e);
        rd_d2  = rd_d1;
        rd_d1  = rd;
        m_wr   = nxt;
        m_full = e.full;
        m_ovf  = e.ovf;
        @(posedge wr_clk);
        #1;
        o = sb_q.pop_front();
        checks++;
        if (f_full !== o.full) begin
            failures++;
            $display("FAIL %s sb_f_full wr_ptr=%0d: got %b want %b", cur_test, nxt, f_full, o.full);
        end
        checks++;
        if (wr_ptr_gray !== o.gray) begin
            failures++;
            $display("FAIL %s sb_wr_ptr_gray wr_ptr=%0d: got %b want %b", cur_test, nxt, wr_ptr_gray, o.gray);
        end
        checks++;
        if (wr_level !== o.level) begin
            failures++;
            $display("FAIL %s sb_wr_level wr_ptr=%0d: got %0d want %0d", cur_test, nxt, wr_level, o.level);
        end
        checks++;
        if (wr_overflow !== o.ovf) begin
            failures++;
            $display("FAIL %s sb_wr_overflow wr_ptr=%0d: got %b want %b", cur_test, nxt, wr_overflow, o.ovf);
        end
`ifdef FULL_ALMOST_EN
        checks++;
        if (f_almost_full !== o.af) begin
            failures++;
            $display("FAIL %s sb_f_almost_full wr_ptr=%0d: got %b want %b", cur_test, nxt, f_almost_full, o.af);
        end
`endif
    endtask

    task automatic do_reset();
        @(posedge wr_clk);
        #1;
        reset         = 1'b1;
        wr_ptr        = '0;
        enable_wr_out = 1'b0;
        enable_wr     = 1'b0;
        rd_ptr_gray   = '0;
        m_wr   = '0;
        rd_d1  = '0;
        rd_d2  = '0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        @(posedge wr_clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 5'd0);
        // Assert mid-cycle; outputs must clear before the next edge.
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (f_full !== 1'b0) begin failures++; $display("FAIL reset f_full: got %b want 0", f_full); end
        checks++;
        if (wr_ptr_gray !== 5'd0) begin failures++; $display("FAIL reset wr_ptr_gray: got %b want 00000", wr_ptr_gray); end
        checks++;
        if (wr_level !== 5'd0) begin failures++; $display("FAIL reset wr_level: got %0d want 0", wr_level); end
        checks++;
        if (wr_overflow !== 1'b0) begin failures++; $display("FAIL reset wr_overflow: got %b want 0", wr_overflow); end
`ifdef FULL_ALMOST_EN
        checks++;
        if (f_almost_full !== 1'b0) begin failures++; $display("FAIL reset f_almost_full: got %b want 0", f_almost_full); end
`endif
        do_reset();
    endtask

    task automatic test_fill();
        cur_test = "fill";
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 5'd0);
        checks++;
        if (f_full !== 1'b0) begin failures++; $display("FAIL fill_15 f_full: got %b want 0", f_full); end
        step(1'b1, 1'b1, 5'd0);
        checks++;
        if (f_full !== 1'b1) begin failures++; $display("FAIL fill_16 f_full: got %b want 1", f_full); end
        checks++;
        if (wr_level !== 5'd16) begin failures++; $display("FAIL fill_16 wr_level: got %0d want 16", wr_level); end
        step(1'b0, 1'b1, 5'd0);
        checks++;
        if (wr_overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf wr_overflow: got %b want 1", wr_overflow); end
        step(1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0);
        checks++;
        if (wr_overflow !== 1'b1) begin failures++; $display("FAIL fill_sticky wr_overflow: got %b want 1", wr_overflow); end
    endtask

    task automatic test_drain();
        cur_test = "drain";
        step(1'b0, 1'b0, 5'd1);
        step(1'b0, 1'b0, 5'd1);
        checks++;
        if (f_full !== 1'b1) begin failures++; $display("FAIL drain_n2 f_full: got %b want 1", f_full); end
        step(1'b0, 1'b0, 5'd1);
        checks++;
        if (f_full !== 1'b0) begin failures++; $display("FAIL drain_n3 f_full: got %b want 0", f_full); end
        checks++;
        if (wr_level !== 5'd15) begin failures++; $display("FAIL drain_n3 wr_level: got %0d want 15", wr_level); end
    endtask

    task automatic test_wrap();
        cur_test = "wrap";
        do_reset();
        m_wr = 5'd30;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd16);
        checks++;
        if (wr_ptr_gray !== 5'b10001) begin failures++; $display("FAIL wrap_30 wr_ptr_gray: got %b want 10001", wr_ptr_gray); end
        step(1'b1, 1'b1, 5'd16);
        checks++;
        if (wr_ptr_gray !== 5'b10000) begin failures++; $display("FAIL wrap_31 wr_ptr_gray: got %b want 10000", wr_ptr_gray); end
        checks++;
        if (f_full !== 1'b0) begin failures++; $display("FAIL wrap_31 f_full: got %b want 0", f_full); end
        step(1'b1, 1'b1, 5'd16);
        checks++;
        if (wr_ptr_gray !== 5'b00000) begin failures++; $display("FAIL wrap_0 wr_ptr_gray: got %b want 00000", wr_ptr_gray); end
        checks++;
        if (f_full !== 1'b1) begin failures++; $display("FAIL wrap_0 f_full: got %b want 1", f_full); end
        step(1'b0, 1'b0, 5'd16);
    endtask

    task automatic test_simultaneous();
        cur_test = "simultaneous";
        do_reset();
        m_wr = 5'd15;
        step(1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd1);
        step(1'b0, 1'b0, 5'd1);
        step(1'b1, 1'b1, 5'd1);
        checks++;
        if (f_full !== 1'b0) begin failures++; $display("FAIL simul f_full: got %b want 0", f_full); end
        checks++;
        if (wr_level !== 5'd15) begin failures++; $display("FAIL simul wr_level: got %0d want 15", wr_level); end
        step(1'b0, 1'b0, 5'd1);
    endtask

    task automatic test_almost_full();
        cur_test = "almost_full";
        do_reset();
        for (int i = 0; i < 13; i++) step(1'b1, 1'b1, 5'd0);
        checks++;
        if (wr_level !== 5'd13) begin failures++; $display("FAIL af_13 wr_level: got %0d want 13", wr_level); end
`ifdef FULL_ALMOST_EN
        checks++;
        if (f_almost_full !== 1'b0) begin failures++; $display("FAIL af_13 f_almost_full: got %b want 0", f_almost_full); end
`endif
        step(1'b1, 1'b1, 5'd0);
        checks++;
        if (wr_level !== 5'd14) begin failures++; $display("FAIL af_14 wr_level: got %0d want 14", wr_level); end
`ifdef FULL_ALMOST_EN
        checks++;
        if (f_almost_full !== 1'b1) begin failures++; $display("FAIL af_14 f_almost_full: got %b want 1", f_almost_full); end
`endif
        step(1'b1, 1'b1, 5'd0);
        step(1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        reset         = 1'b1;
        wr_ptr        = '0;
        enable_wr_out = 1'b0;
        enable_wr     = 1'b0;
        rd_ptr_gray   = '0;
        m_wr   = '0;
        rd_d1  = '0;
        rd_d2  = '0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        do_reset();
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_almost_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
